// File: rtl/mem_unit_lsq.sv
// Load/store reservation station with a single memory port.
// Buffers up to ENTRIES memory ops, snoops CDB_N result buses for pending
// operands, issues the op whose tag is at the ROB head, runs one memory
// request at a time and broadcasts the (extended) load result.
module mem_unit_lsq #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int CDB_N   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // dispatch
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_target,
  input  logic                     in_store,
  input  logic [2:0]               in_width,
  input  logic [XLEN-1:0]          in_offset,
  input  logic [XLEN-1:0]          in_val1,
  input  logic [XLEN-1:0]          in_val2,
  input  logic [TAG_W-1:0]         in_tag1,
  input  logic [TAG_W-1:0]         in_tag2,
  // result bus snoop
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_N*XLEN-1:0]    cdb_val,
  // ROB head
  input  logic                     rob_head_valid,
  input  logic [TAG_W-1:0]         rob_head_tag,
  // memory port
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [3:0]               mem_be,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic                     mem_done,
  input  logic [XLEN-1:0]          mem_rdata,
  // completion
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_target,
  output logic [XLEN-1:0]          out_result
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  // Returns {hit, value} for the bus (if any) currently broadcasting tag t.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]       t,
    input logic [CDB_N-1:0]       v,
    input logic [CDB_N*TAG_W-1:0] tg,
    input logic [CDB_N*XLEN-1:0]  vl
  );
    logic [XLEN:0] r;
    r = '0;
    for (int b = 0; b < CDB_N; b++) begin
      if (v[b] && (tg[b*TAG_W +: TAG_W] == t)) begin
        r = {1'b1, vl[b*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  // Byte lane of the access: B uses a[1:0], H drops a[0], W is forced to 0.
  function automatic logic [1:0] lane_of(input logic [2:0] w, input logic [1:0] a);
    logic [1:0] l;
    case (w[1:0])
      2'd0:    l = a;
      2'd1:    l = {a[1], 1'b0};
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] w, input logic [1:0] lane);
    logic [3:0] be;
    case (w[1:0])
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Entry storage
  logic             valid_reg  [ENTRIES];
  logic [TAG_W-1:0] target_reg [ENTRIES];
  logic             store_reg  [ENTRIES];
  logic [2:0]       width_reg  [ENTRIES];
  logic [XLEN-1:0]  offset_reg [ENTRIES];
  logic [XLEN-1:0]  val1_reg   [ENTRIES];
  logic [XLEN-1:0]  val2_reg   [ENTRIES];
  logic [TAG_W-1:0] tag1_reg   [ENTRIES];
  logic [TAG_W-1:0] tag2_reg   [ENTRIES];

  // Issue / FSM state
  state_t           state_reg;
  logic [IDX_W-1:0] sel_reg;
  logic             store_q_reg;
  logic [2:0]       width_q_reg;
  logic [1:0]       lane_q_reg;

  // Combinational helpers
  logic             full;
  logic [IDX_W-1:0] alloc_idx;
  logic             issue_hit;
  logic [IDX_W-1:0] issue_idx;
  logic [TAG_W-1:0] disp_tag1, disp_tag2;
  logic [XLEN-1:0]  disp_val1, disp_val2;
  logic [XLEN:0]    disp_snoop1, disp_snoop2;
  logic [XLEN-1:0]  iss_addr;
  logic [1:0]       iss_lane;
  logic [XLEN-1:0]  rdata_shifted;
  logic [XLEN-1:0]  load_ext;

  assign in_ready = !full;

  // Occupancy and lowest free slot, from registered state only.
  always_comb begin
    full      = 1'b1;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        full      = 1'b0;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Dispatch operands may be satisfied by a bus broadcasting in the same cycle.
  assign disp_snoop1 = cdb_lookup(in_tag1, cdb_valid, cdb_tag, cdb_val);
  assign disp_snoop2 = cdb_lookup(in_tag2, cdb_valid, cdb_tag, cdb_val);

  always_comb begin
    disp_tag1 = in_tag1;
    disp_val1 = in_val1;
    disp_tag2 = in_tag2;
    disp_val2 = in_val2;
    if ((in_tag1 != TAG_INVALID) && disp_snoop1[XLEN]) begin
      disp_tag1 = TAG_INVALID;
      disp_val1 = disp_snoop1[XLEN-1:0];
    end
    if ((in_tag2 != TAG_INVALID) && disp_snoop2[XLEN]) begin
      disp_tag2 = TAG_INVALID;
      disp_val2 = disp_snoop2[XLEN-1:0];
    end
  end

  // Pick the ready entry whose tag is the ROB head (tags are unique).
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_reg[i] && (tag1_reg[i] == TAG_INVALID) && (tag2_reg[i] == TAG_INVALID) &&
          rob_head_valid && (target_reg[i] == rob_head_tag)) begin
        issue_hit = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign iss_addr = val1_reg[issue_idx] + offset_reg[issue_idx];
  assign iss_lane = lane_of(width_reg[issue_idx], iss_addr[1:0]);

  // Load data: move the addressed lane down, then extend by width.
  assign rdata_shifted = mem_rdata >> {lane_q_reg, 3'b000};

  always_comb begin
    case (width_q_reg)
      3'd0:    load_ext = {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'd4:    load_ext = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
      3'd1:    load_ext = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'd5:    load_ext = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [XLEN:0] snoop1;
      logic [XLEN:0] snoop2;
      logic          do_alloc;
      logic          do_free;

      assign snoop1   = cdb_lookup(tag1_reg[gi], cdb_valid, cdb_tag, cdb_val);
      assign snoop2   = cdb_lookup(tag2_reg[gi], cdb_valid, cdb_tag, cdb_val);
      assign do_alloc = in_valid && !full && (alloc_idx == IDX_W'(gi));
      assign do_free  = (state_reg == S_WAIT) && mem_done && (sel_reg == IDX_W'(gi));

      // Per-entry update: allocate into a free slot, or snoop/free a held one.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi]  <= 1'b0;
          target_reg[gi] <= TAG_INVALID;
          store_reg[gi]  <= 1'b0;
          width_reg[gi]  <= 3'd0;
          offset_reg[gi] <= '0;
          val1_reg[gi]   <= '0;
          val2_reg[gi]   <= '0;
          tag1_reg[gi]   <= TAG_INVALID;
          tag2_reg[gi]   <= TAG_INVALID;
        end else if (do_alloc) begin
          valid_reg[gi]  <= 1'b1;
          target_reg[gi] <= in_target;
          store_reg[gi]  <= in_store;
          width_reg[gi]  <= in_width;
          offset_reg[gi] <= in_offset;
          val1_reg[gi]   <= disp_val1;
          val2_reg[gi]   <= disp_val2;
          tag1_reg[gi]   <= disp_tag1;
          tag2_reg[gi]   <= disp_tag2;
        end else begin
          if (do_free) begin
            valid_reg[gi] <= 1'b0;
          end
          if (valid_reg[gi] && (tag1_reg[gi] != TAG_INVALID) && snoop1[XLEN]) begin
            val1_reg[gi] <= snoop1[XLEN-1:0];
            tag1_reg[gi] <= TAG_INVALID;
          end
          if (valid_reg[gi] && (tag2_reg[gi] != TAG_INVALID) && snoop2[XLEN]) begin
            val2_reg[gi] <= snoop2[XLEN-1:0];
            tag2_reg[gi] <= TAG_INVALID;
          end
        end
      end
    end
  endgenerate

  // Issue FSM: IDLE picks the head op, WAIT holds the request until mem_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      sel_reg     <= '0;
      store_q_reg <= 1'b0;
      width_q_reg <= 3'd0;
      lane_q_reg  <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
      out_valid   <= 1'b0;
      out_target  <= TAG_INVALID;
      out_result  <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_target <= TAG_INVALID;
      out_result <= '0;
      case (state_reg)
        S_IDLE: begin
          if (issue_hit) begin
            state_reg   <= S_WAIT;
            sel_reg     <= issue_idx;
            store_q_reg <= store_reg[issue_idx];
            width_q_reg <= width_reg[issue_idx];
            lane_q_reg  <= iss_lane;
            mem_req     <= 1'b1;
            mem_we      <= store_reg[issue_idx];
            mem_addr    <= iss_addr;
            mem_be      <= be_of(width_reg[issue_idx], iss_lane);
            mem_wdata   <= store_reg[issue_idx] ? (val2_reg[issue_idx] << {iss_lane, 3'b000}) : '0;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            state_reg  <= S_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            out_valid  <= 1'b1;
            out_target <= target_reg[sel_reg];
            out_result <= store_q_reg ? '0 : load_ext;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit_lsq.sv
// Self-checking bench for mem_unit_lsq: directed scenarios plus randomized
// single-op traffic compared against a byte-level reference model.
module tb_mem_unit_lsq;
  localparam int ENTRIES = 4;
  localparam int TAG_W   = 4;
  localparam int XLEN    = 32;
  localparam int CDB_N   = 2;
  localparam logic [3:0] TINV = 4'hF;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAG_W-1:0]       in_target;
  logic                   in_store;
  logic [2:0]             in_width;
  logic [XLEN-1:0]        in_offset, in_val1, in_val2;
  logic [TAG_W-1:0]       in_tag1, in_tag2;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_val;
  logic                   rob_head_valid;
  logic [TAG_W-1:0]       rob_head_tag;
  logic                   mem_req, mem_we;
  logic [XLEN-1:0]        mem_addr;
  logic [3:0]             mem_be;
  logic [XLEN-1:0]        mem_wdata;
  logic                   mem_done;
  logic [XLEN-1:0]        mem_rdata;
  logic                   out_valid;
  logic [TAG_W-1:0]       out_target;
  logic [XLEN-1:0]        out_result;

  int tests = 0;
  int fails = 0;

  mem_unit_lsq #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .XLEN(XLEN), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_store(in_store),
    .in_width(in_width), .in_offset(in_offset), .in_val1(in_val1), .in_val2(in_val2),
    .in_tag1(in_tag1), .in_tag2(in_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_target(out_target), .out_result(out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] w);
    if (w == 3'd0 || w == 3'd4) return 1;
    if (w == 3'd1 || w == 3'd5) return 2;
    return 4;
  endfunction

  // Lane = address within word rounded down to the access size; words use 0.
  function automatic int lane(input logic [2:0] w, input logic [31:0] a);
    int n;
    int r;
    n = nbytes(w);
    if (n == 4) return 0;
    r = int'(a % 4);
    return r - (r % n);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] w, input logic [31:0] a);
    int n;
    n = nbytes(w);
    return 4'(((1 << n) - 1) << lane(w, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] w, input logic [31:0] a, input logic [31:0] v);
    return v << (8 * lane(w, a));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] mask;
    logic [31:0] v;
    int n;
    n    = nbytes(w);
    v    = rd >> (8 * lane(w, a));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask[31:0];
    if (n < 4 && (w == 3'd0 || w == 3'd1) && v[8*n-1]) v = v | ~mask[31:0];
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_target = 0; in_store = 0; in_width = 0; in_offset = 0;
    in_val1 = 0; in_val2 = 0; in_tag1 = TINV; in_tag2 = TINV;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
    rob_head_valid = 0; rob_head_tag = 0; mem_done = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // Offer one op for a cycle with an optional simultaneous bus broadcast.
  task automatic dispatch(input logic [3:0] tgt, input logic st, input logic [2:0] w,
                          input logic [31:0] off, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [3:0] t1, input logic [3:0] t2,
                          input logic [1:0] cv, input logic [7:0] ct, input logic [63:0] cval);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL dispatch_ready tgt=%0d: in_ready=%b required 1", tgt, in_ready);
    end
    in_valid = 1; in_target = tgt; in_store = st; in_width = w; in_offset = off;
    in_val1 = v1; in_val2 = v2; in_tag1 = t1; in_tag2 = t2;
    cdb_valid = cv; cdb_tag = ct; cdb_val = cval;
    tick();
    in_valid = 0; in_tag1 = TINV; in_tag2 = TINV; cdb_valid = 0;
  endtask

  // Make tgt the ROB head, expect its request, then complete it with rdata.
  task automatic do_complete(input string nm, input logic [3:0] tgt, input logic st,
                             input logic [2:0] w, input logic [31:0] base, input logic [31:0] off,
                             input logic [31:0] v2, input logic [31:0] rd);
    logic [31:0] a;
    int n;
    int hold;
    a = base + off;
    rob_head_valid = 1; rob_head_tag = tgt;
    n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL %s issue: mem_req=%b required 1 within 10 cycles", nm, mem_req);
      rob_head_valid = 0;
      return;
    end
    hold = $urandom_range(0, 2);
    for (int k = 0; k <= hold; k++) begin
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_be !== model_be(w, a) || mem_we !== st) begin
        fails++;
        $display("FAIL %s req: req=%b addr=%h be=%b we=%b required 1 %h %b %b",
                 nm, mem_req, mem_addr, mem_be, mem_we, a, model_be(w, a), st);
      end
      if (st) begin
        tests++;
        if (mem_wdata !== model_wdata(w, a, v2)) begin
          fails++;
          $display("FAIL %s wdata: got %h required %h", nm, mem_wdata, model_wdata(w, a, v2));
        end
      end
      if (k < hold) tick();
    end
    mem_done = 1; mem_rdata = rd;
    tick();
    mem_done = 0; mem_rdata = $urandom;
    tests++;
    if (out_valid !== 1'b1 || out_target !== tgt || mem_req !== 1'b0 ||
        out_result !== (st ? 32'd0 : model_load(w, a, rd))) begin
      fails++;
      $display("FAIL %s done: valid=%b tgt=%0d req=%b result=%h required 1 %0d 0 %h",
               nm, out_valid, out_target, mem_req, out_result, tgt, st ? 32'd0 : model_load(w, a, rd));
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_target !== TINV) begin
      fails++;
      $display("FAIL %s pulse: valid=%b tgt=%h required 0 f", nm, out_valid, out_target);
    end
    rob_head_valid = 0;
    $display("[TB] op %s tgt=%0d st=%0d w=%0d addr=%h", nm, tgt, st, w, a);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || out_target !== TINV || out_valid !== 1'b0 ||
        out_result !== 32'd0 || mem_be !== 4'b0 || mem_addr !== 32'd0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset: ready=%b req=%b tgt=%h valid=%b res=%h be=%b addr=%h we=%b",
               in_ready, mem_req, out_target, out_valid, out_result, mem_be, mem_addr, mem_we);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_lb();
    dispatch(4'd1, 0, 3'd0, 32'd3, 32'h100, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    do_complete("lb", 4'd1, 0, 3'd0, 32'h100, 32'd3, 32'd0, 32'h80123456);
    dispatch(4'd2, 0, 3'd4, 32'd3, 32'h100, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    do_complete("lbu", 4'd2, 0, 3'd4, 32'h100, 32'd3, 32'd0, 32'h80123456);
  endtask

  task automatic test_sh_snoop();
    rob_head_valid = 1; rob_head_tag = 4'd3;
    dispatch(4'd3, 1, 3'd1, 32'd2, 32'hDEAD, 32'hBEEF, 4'd5, TINV, 2'b00, 8'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (mem_req !== 1'b0) begin
        fails++;
        $display("FAIL sh_pending: mem_req=%b required 0", mem_req);
      end
      tick();
    end
    cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_val = {32'h200, 32'h0};
    tick();
    cdb_valid = 0;
    do_complete("sh", 4'd3, 1, 3'd1, 32'h200, 32'd2, 32'hBEEF, 32'hFFFFFFFF);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      dispatch(4'(i), 0, 3'd2, 32'd4, 32'(i * 16), 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
      tests++;
      if (in_ready !== (i < 4)) begin
        fails++;
        $display("FAIL fill_ready %0d: in_ready=%b required %b", i, in_ready, i < 4);
      end
    end
    rob_head_valid = 1; rob_head_tag = 4'd2;
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd36) begin
      fails++;
      $display("FAIL fill_issue: req=%b addr=%h required 1 00000024", mem_req, mem_addr);
    end
    mem_done = 1; mem_rdata = 32'h11112222;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_not_yet: in_ready=%b required 0", in_ready);
    end
    tick();
    mem_done = 0; rob_head_valid = 0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_target !== 4'd2 || out_result !== 32'h11112222) begin
      fails++;
      $display("FAIL fill_free: ready=%b valid=%b tgt=%0d res=%h required 1 1 2 11112222",
               in_ready, out_valid, out_target, out_result);
    end
    dispatch(4'd6, 0, 3'd5, 32'd2, 32'h60, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_refull: in_ready=%b required 0", in_ready);
    end
    do_complete("fill1", 4'd1, 0, 3'd2, 32'd16, 32'd4, 32'd0, 32'hA5A5A5A5);
    do_complete("fill6", 4'd6, 0, 3'd5, 32'h60, 32'd2, 32'd0, 32'h9ABC1234);
    do_complete("fill3", 4'd3, 0, 3'd2, 32'd48, 32'd4, 32'd0, 32'h01020304);
    do_complete("fill4", 4'd4, 0, 3'd2, 32'd64, 32'd4, 32'd0, 32'hCAFEF00D);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_drain: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_order();
    dispatch(4'd7, 0, 3'd1, 32'd1, 32'h400, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    rob_head_valid = 1; rob_head_tag = 4'd8;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (mem_req !== 1'b0) begin
        fails++;
        $display("FAIL order_wrong_head: mem_req=%b required 0", mem_req);
      end
    end
    rob_head_valid = 0; rob_head_tag = 4'd7;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (mem_req !== 1'b0) begin
        fails++;
        $display("FAIL order_head_invalid: mem_req=%b required 0", mem_req);
      end
    end
    do_complete("order", 4'd7, 0, 3'd1, 32'h400, 32'd1, 32'd0, 32'h0000F00F);
  endtask

  task automatic test_back_to_back();
    dispatch(4'd10, 0, 3'd0, 32'd1, 32'h500, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    dispatch(4'd11, 1, 3'd0, 32'd3, 32'hDDDD, 32'h5A, 4'd6, TINV, 2'b00, 8'h0, 64'h0);
    rob_head_valid = 1; rob_head_tag = 4'd10;
    tick();
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL b2b_issue: mem_req=%b required 1", mem_req);
    end
    // completion of 10, dispatch of 12 (captures bus0) and snoop of 11 (bus1) together
    mem_done = 1; mem_rdata = 32'h0000C300;
    in_valid = 1; in_target = 4'd12; in_store = 0; in_width = 3'd1; in_offset = 32'd2;
    in_val1 = 32'hEEEE; in_val2 = 0; in_tag1 = 4'd9; in_tag2 = TINV;
    cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd9}; cdb_val = {32'h600, 32'h700};
    tick();
    mem_done = 0; in_valid = 0; in_tag1 = TINV; cdb_valid = 0;
    tests++;
    if (out_valid !== 1'b1 || out_target !== 4'd10 || out_result !== model_load(3'd0, 32'h501, 32'h0000C300)) begin
      fails++;
      $display("FAIL b2b_done: valid=%b tgt=%0d res=%h", out_valid, out_target, out_result);
    end
    rob_head_tag = 4'd11;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: out_valid=%b required 0", out_valid);
    end
    do_complete("b2b11", 4'd11, 1, 3'd0, 32'h600, 32'd3, 32'h5A, 32'd0);
    do_complete("b2b12", 4'd12, 0, 3'd1, 32'h700, 32'd2, 32'd0, 32'h8001FFFF);
  endtask

  task automatic test_reset_mid_wait();
    dispatch(4'd9, 1, 3'd2, 32'd0, 32'h800, 32'h12345678, TINV, TINV, 2'b00, 8'h0, 64'h0);
    rob_head_valid = 1; rob_head_tag = 4'd9;
    tick();
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL rstwait_issue: mem_req=%b required 1", mem_req);
    end
    rst = 1;
    tick();
    rst = 0; mem_done = 1;
    tick();
    mem_done = 0;
    tests++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstwait_ignore: valid=%b req=%b ready=%b required 0 0 1", out_valid, mem_req, in_ready);
    end
    rob_head_valid = 0;
    for (int i = 0; i < 3; i++) begin
      dispatch(4'(i), 0, 3'd2, 32'd0, 32'd0, 32'd0, TINV, TINV, 2'b00, 8'h0, 64'h0);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstwait_empty: in_ready=%b required 1 after 3 ops", in_ready);
    end
    do_reset();
    $display("[TB] reset mid-wait checked");
  endtask

  task automatic test_random();
    logic [2:0] wt [5];
    logic [3:0] tgt, ptag;
    logic [2:0] w;
    logic [31:0] base, off, v2, rd;
    logic st;
    int mode, b;
    logic [7:0] ct;
    logic [63:0] cv;
    wt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int it = 0; it < 40; it++) begin
      tgt  = 4'($urandom_range(0, 14));
      ptag = 4'($urandom_range(0, 14));
      st   = 1'($urandom_range(0, 1));
      w    = wt[$urandom_range(0, 4)];
      base = $urandom; off = $urandom; v2 = $urandom; rd = $urandom;
      mode = $urandom_range(0, 2);
      b    = $urandom_range(0, CDB_N - 1);
      ct = 8'h0; cv = 64'h0;
      ct[b*4 +: 4]  = ptag;
      cv[b*32 +: 32] = base;
      if (mode == 0) begin
        dispatch(tgt, st, w, off, base, v2, TINV, TINV, 2'b00, 8'h0, 64'h0);
      end else if (mode == 1) begin
        dispatch(tgt, st, w, off, ~base, v2, ptag, TINV, 2'b00, 8'h0, 64'h0);
        tick();
        cdb_valid = 2'(1 << b); cdb_tag = ct; cdb_val = cv;
        tick();
        cdb_valid = 0;
      end else begin
        dispatch(tgt, st, w, off, ~base, v2, ptag, TINV, 2'(1 << b), ct, cv);
      end
      do_complete($sformatf("rnd%0d", it), tgt, st, w, base, off, v2, rd);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    test_reset();
    test_lb();
    test_sh_snoop();
    test_fill();
    test_order();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
